// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one op in flight.
// Optional MULDIV_EARLY_OUT_EN: trivial ops (zero operand, divide by zero, signed overflow) skip CALC.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      RdIn,
    output logic            Busy,
    output logic            Valid,
    output logic [XLEN-1:0] Result,
    output logic [4:0]      RdOut
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    state_e state_q, state_d;

    op_e             op_q;
    logic [4:0]      rd_q;
    logic            neg_q;
    logic            div_zero_q;
    logic            ovf_q;
    logic            mul_zero_q;
    logic [XLEN-1:0] a_raw_q;
    logic [XLEN-1:0] opnd_q;   // multiplicand magnitude, or divisor magnitude
    logic [XLEN-1:0] hi_q;     // product high half, or partial remainder
    logic [XLEN-1:0] lo_q;     // multiplier / product low half, or quotient
    logic [CNT_W-1:0] cnt_q;

    // Request decode, evaluated against the live inputs at the accepting edge.
    op_e             op_in;
    logic            in_is_div;
    logic            in_a_signed;
    logic            in_b_signed;
    logic            in_sign_a;
    logic            in_sign_b;
    logic [XLEN-1:0] in_mag_a;
    logic [XLEN-1:0] in_mag_b;
    logic            in_a_zero;
    logic            in_b_zero;
    logic            in_ovf;
    logic            in_neg;
    logic            early_out;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        op_in       = op_e'(Funct3);
        in_is_div   = Funct3[2];
        in_a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
        in_b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        in_sign_a   = in_a_signed & A[XLEN-1];
        in_sign_b   = in_b_signed & B[XLEN-1];
        in_mag_a    = in_sign_a ? -A : A;
        in_mag_b    = in_sign_b ? -B : B;
        in_a_zero   = (A == '0);
        in_b_zero   = (B == '0);
        in_ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) && (A == INT_MIN) && (B == '1);
        // Remainder follows the dividend's sign; unsigned ops have both signs forced to 0.
        in_neg      = (op_in == OP_REM) ? in_sign_a : (in_sign_a ^ in_sign_b);
`ifdef MULDIV_EARLY_OUT_EN
        early_out   = in_is_div ? (in_b_zero | in_ovf) : (in_a_zero | in_b_zero);
`else
        early_out   = 1'b0;
`endif
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = early_out ? S_FIX : S_CALC;
            S_CALC:  if (cnt_q == LAST_ITER) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state_q != S_IDLE);
        Valid = (state_q == S_DONE);
    end

    // One iteration of each algorithm; only the one matching op_q is committed.
    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
    end

    // Sign correction and special-case override, registered at the FIX edge.
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo_q : lo_q;
        rem_fix  = neg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:
                fix_result = mul_zero_q ? '0 : prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:
                fix_result = mul_zero_q ? '0 : prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:
                fix_result = div_zero_q ? '1 : (ovf_q ? INT_MIN : quo_fix);
            OP_REM, OP_REMU:
                fix_result = div_zero_q ? a_raw_q : (ovf_q ? '0 : rem_fix);
            default:
                fix_result = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_q       <= OP_MUL;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            mul_zero_q <= 1'b0;
            a_raw_q    <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            Result     <= '0;
            RdOut      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        op_q       <= op_in;
                        rd_q       <= RdIn;
                        neg_q      <= in_neg;
                        div_zero_q <= in_b_zero;
                        ovf_q      <= in_ovf;
                        mul_zero_q <= in_a_zero | in_b_zero;
                        a_raw_q    <= A;
                        cnt_q      <= '0;
                        hi_q       <= '0;
                        if (in_is_div) begin
                            lo_q   <= in_mag_a;
                            opnd_q <= in_mag_b;
                        end else begin
                            lo_q   <= in_mag_b;
                            opnd_q <= in_mag_a;
                        end
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (op_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            hi_q <= div_diff[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_q <= div_shift[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi_q <= mul_sum[XLEN:1];
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    Result <= fix_result;
                    RdOut  <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, MUL/DIV variants, special cases,
// busy-time Start rejection and mid-operation reset abort.
module tb_muldiv_unit;

    localparam int XLEN     = 32;
    localparam int LAT_FULL = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 2;
`else
    localparam int LAT_SPECIAL = 34;
`endif

    logic            Clk;
    logic            Rst;
    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [4:0]      RdIn;
    logic            Busy;
    logic            Valid;
    logic [XLEN-1:0] Result;
    logic [4:0]      RdOut;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Funct3 (Funct3),
        .A      (A),
        .B      (B),
        .RdIn   (RdIn),
        .Busy   (Busy),
        .Valid  (Valid),
        .Result (Result),
        .RdOut  (RdOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Issues one op and waits (bounded) for Valid; lat = posedges from Start to Valid, -1 on timeout.
    // Operand inputs are scrambled right after the accepting edge. Returns one cycle after Valid.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output logic valid_after, output logic busy_after);
        @(negedge Clk);
        Start = 1'b1; Funct3 = f3; A = a; B = b; RdIn = rd;
        lat = -1; res = '0; rdo = '0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge Clk); #1;
            if (i == 1) begin
                Start = 1'b0; Funct3 = 3'd5; A = 32'hDEAD_BEEF; B = 32'h1234_5678; RdIn = 5'd31;
            end
            if (Valid) begin
                lat = i; res = Result; rdo = RdOut;
                break;
            end
        end
        @(posedge Clk); #1;
        valid_after = Valid;
        busy_after  = Busy;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; Funct3 = '0; A = '0; B = '0; RdIn = '0;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++; if (Busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Valid); end
        n_checks++; if (Result !== '0)  begin n_fail++; $display("FAIL reset_result: got %h expected 0", Result); end
        n_checks++; if (RdOut !== '0)   begin n_fail++; $display("FAIL reset_rdout: got %0d expected 0", RdOut); end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_mul_latency();
        logic [31:0] res; logic [4:0] rdo; int lat; logic va, ba;
        run_op(3'd0, 32'd7, 32'd6, 5'd5, res, rdo, lat, va, ba);
        n_checks++; if (lat !== LAT_FULL) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", lat, LAT_FULL); end
        n_checks++; if (res !== 32'd42)   begin n_fail++; $display("FAIL mul_result: got %h expected %h", res, 32'd42); end
        n_checks++; if (rdo !== 5'd5)     begin n_fail++; $display("FAIL mul_rdout: got %0d expected 5", rdo); end
        n_checks++; if (va !== 1'b0)      begin n_fail++; $display("FAIL mul_valid_one_cycle: got %b expected 0", va); end
        n_checks++; if (ba !== 1'b0)      begin n_fail++; $display("FAIL mul_busy_after: got %b expected 0", ba); end
        n_checks++; if (Result !== 32'd42) begin n_fail++; $display("FAIL mul_result_hold: got %h expected %h", Result, 32'd42); end
    endtask

    task automatic test_mul_high();
        logic [31:0] res; logic [4:0] rdo; int lat; logic va, ba;
        logic [2:0]  f3 [3]  = '{3'd1, 3'd3, 3'd2};
        logic [31:0] va_ [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb_ [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int k = 0; k < 3; k++) begin
            run_op(f3[k], va_[k], vb_[k], 5'(k + 1), res, rdo, lat, va, ba);
            n_checks++; if (res !== exp[k]) begin n_fail++; $display("FAIL mulh_result[%0d]: got %h expected %h", k, res, exp[k]); end
            n_checks++; if (lat !== LAT_FULL) begin n_fail++; $display("FAIL mulh_latency[%0d]: got %0d expected %0d", k, lat, LAT_FULL); end
        end
    endtask

    task automatic test_divide();
        logic [31:0] res; logic [4:0] rdo; int lat; logic va, ba;
        logic [2:0]  f3 [4]  = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] va_ [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] vb_ [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int k = 0; k < 4; k++) begin
            run_op(f3[k], va_[k], vb_[k], 5'(k + 10), res, rdo, lat, va, ba);
            n_checks++; if (res !== exp[k]) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", k, res, exp[k]); end
            n_checks++; if (lat !== LAT_FULL) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected %0d", k, lat, LAT_FULL); end
        end
    endtask

    task automatic test_special();
        logic [31:0] res; logic [4:0] rdo; int lat; logic va, ba;
        logic [2:0]  f3 [8]  = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd1};
        logic [31:0] va_ [8] = '{32'd123, 32'd123, 32'h8000_0000, 32'h8000_0000,
                                 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0, 32'h1234_5678};
        logic [31:0] vb_ [8] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd0, 32'd0, 32'd5, 32'd0};
        logic [31:0] exp [8] = '{32'hFFFF_FFFF, 32'd123, 32'h8000_0000, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0, 32'd0};
        for (int k = 0; k < 8; k++) begin
            run_op(f3[k], va_[k], vb_[k], 5'(k + 20), res, rdo, lat, va, ba);
            n_checks++; if (res !== exp[k]) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", k, res, exp[k]); end
            n_checks++; if (lat !== LAT_SPECIAL) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected %0d", k, lat, LAT_SPECIAL); end
            n_checks++; if (rdo !== 5'(k + 20)) begin n_fail++; $display("FAIL special_rdout[%0d]: got %0d expected %0d", k, rdo, k + 20); end
        end
    endtask

    // Extra Start pulses while busy (including one sampled in DONE) must all be dropped.
    task automatic test_back_to_back();
        int n_valid = 0; int first = -1;
        logic [31:0] res = '0; logic [4:0] rdo = '0;
        @(negedge Clk);
        Start = 1'b1; Funct3 = 3'd0; A = 32'd7; B = 32'd6; RdIn = 5'd5;
        for (int i = 1; i <= 45; i++) begin
            @(posedge Clk); #1;
            Start = (i == 5) || (i == 10) || (i == 34);
            if (i == 1) begin Funct3 = 3'd5; A = 32'd100; B = 32'd7; RdIn = 5'd9; end
            if (Valid) begin
                n_valid++; res = Result; rdo = RdOut;
                if (first < 0) first = i;
            end
        end
        n_checks++; if (n_valid !== 1)  begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 1", n_valid); end
        n_checks++; if (first !== LAT_FULL) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", first, LAT_FULL); end
        n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL b2b_result: got %h expected %h", res, 32'd42); end
        n_checks++; if (rdo !== 5'd5)   begin n_fail++; $display("FAIL b2b_rdout: got %0d expected 5", rdo); end
        n_checks++; if (Busy !== 1'b0)  begin n_fail++; $display("FAIL b2b_idle_after: got %b expected 0", Busy); end
    endtask

    task automatic test_reset_abort();
        int n_valid = 0;
        logic [31:0] res; logic [4:0] rdo; int lat; logic va, ba;
        @(negedge Clk);
        Start = 1'b1; Funct3 = 3'd0; A = 32'd7; B = 32'd6; RdIn = 5'd5;
        for (int i = 1; i <= 15; i++) begin
            @(posedge Clk); #1;
            if (i == 1) Start = 1'b0;
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        n_checks++; if (Busy !== 1'b0)  begin n_fail++; $display("FAIL abort_busy: got %b expected 0", Busy); end
        n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", Valid); end
        n_checks++; if (Result !== '0)  begin n_fail++; $display("FAIL abort_result: got %h expected 0", Result); end
        n_checks++; if (RdOut !== '0)   begin n_fail++; $display("FAIL abort_rdout: got %0d expected 0", RdOut); end
        Rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (Valid) n_valid++;
        end
        n_checks++; if (n_valid !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d expected 0", n_valid); end
        run_op(3'd5, 32'd100, 32'd7, 5'd3, res, rdo, lat, va, ba);
        n_checks++; if (res !== 32'd14)   begin n_fail++; $display("FAIL abort_next_result: got %h expected %h", res, 32'd14); end
        n_checks++; if (rdo !== 5'd3)     begin n_fail++; $display("FAIL abort_next_rdout: got %0d expected 3", rdo); end
        n_checks++; if (lat !== LAT_FULL) begin n_fail++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, LAT_FULL); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_mul_high();
        test_divide();
        test_special();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
